btfly_2_pair_buffer: RTL and testbench

//   Input stage of the radix-2 butterfly datapath. Takes a serial complex sample

---
 rtl/btfly_2_pair_buffer.sv | 132 +++++++++++++
 tb/tb_btfly_2_pair_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btfly_2_pair_buffer.sv
// Input pairing stage for the radix-2 butterfly: buffers the first DEPTH samples
// of each 2*DEPTH block and emits registered (x[k], x[k+DEPTH]) operand pairs.
module btfly_2_pair_buffer #(
   parameter int NB_DATA = 8,
   parameter int DEPTH   = 4
) (
   input  logic               i_clock,
   input  logic               i_rst_n,
   input  logic               i_valid,
   input  logic               i_sync,
   input  logic [NB_DATA-1:0] i_data_r,
   input  logic [NB_DATA-1:0] i_data_i,
   output logic               o_valid,
   output logic               o_first,
   output logic               o_last,
   output logic [NB_DATA-1:0] o_data0_r,
   output logic [NB_DATA-1:0] o_data0_i,
   output logic [NB_DATA-1:0] o_data1_r,
   output logic [NB_DATA-1:0] o_data1_i
);

   localparam int NB_CNT  = $clog2(2 * DEPTH);
   localparam int NB_ADDR = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [NB_CNT-1:0] CNT_ZERO = {NB_CNT{1'b0}};
   localparam logic [NB_CNT-1:0] CNT_ONE  = {{(NB_CNT-1){1'b0}}, 1'b1};
   localparam logic [NB_CNT-1:0] CNT_HALF = NB_CNT'(DEPTH);
   localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(2 * DEPTH - 1);

   logic [NB_CNT-1:0]  cnt_r;
   logic [NB_CNT-1:0]  idx_s;
   logic [NB_CNT-1:0]  cnt_next_s;
   logic               pair_s;
   logic               wr_en_s;
   logic               pair_en_s;
   logic               first_s;
   logic               last_s;
   logic [NB_ADDR-1:0] wr_addr_s;
   logic [NB_ADDR-1:0] rd_addr_s;
   logic [NB_DATA-1:0] rd_data_r_s;
   logic [NB_DATA-1:0] rd_data_i_s;

   // Buffer is deliberately left unreset; every entry is refilled before it is read.
   logic [NB_DATA-1:0] mem_re_r [DEPTH];
   logic [NB_DATA-1:0] mem_im_r [DEPTH];

   logic               valid_r;
   logic               first_r;
   logic               last_r;
   logic [NB_DATA-1:0] data0_re_r;
   logic [NB_DATA-1:0] data0_im_r;
   logic [NB_DATA-1:0] data1_re_r;
   logic [NB_DATA-1:0] data1_im_r;

   // Effective block index, phase decode and next counter value.
   always_comb begin
      idx_s      = cnt_r;
      cnt_next_s = CNT_ZERO;
      if (i_valid && i_sync) begin
         idx_s = CNT_ZERO;
      end else begin
         idx_s = cnt_r;
      end
      if (idx_s == CNT_LAST) begin
         cnt_next_s = CNT_ZERO;
      end else begin
         cnt_next_s = idx_s + CNT_ONE;
      end
      pair_s    = (idx_s >= CNT_HALF);
      wr_en_s   = i_valid && !pair_s;
      pair_en_s = i_valid && pair_s;
      first_s   = (idx_s == CNT_HALF);
      last_s    = (idx_s == CNT_LAST);
      wr_addr_s = NB_ADDR'(idx_s);
      rd_addr_s = NB_ADDR'(idx_s - CNT_HALF);
   end

   // Fill and pair phases never coincide, so the read needs no write bypass.
   assign rd_data_r_s = mem_re_r[rd_addr_s];
   assign rd_data_i_s = mem_im_r[rd_addr_s];

   // Block position counter; only accepted samples advance it.
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_r <= CNT_ZERO;
      end else if (i_valid) begin
         cnt_r <= cnt_next_s;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // First-half sample storage.
   always_ff @(posedge i_clock) begin
      if (wr_en_s) begin
         mem_re_r[wr_addr_s] <= i_data_r;
         mem_im_r[wr_addr_s] <= i_data_i;
      end
   end

   // Registered operand pair; data and markers hold across gaps.
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_r    <= 1'b0;
         first_r    <= 1'b0;
         last_r     <= 1'b0;
         data0_re_r <= {NB_DATA{1'b0}};
         data0_im_r <= {NB_DATA{1'b0}};
         data1_re_r <= {NB_DATA{1'b0}};
         data1_im_r <= {NB_DATA{1'b0}};
      end else begin
         valid_r <= pair_en_s;
         if (pair_en_s) begin
            first_r    <= first_s;
            last_r     <= last_s;
            data0_re_r <= rd_data_r_s;
            data0_im_r <= rd_data_i_s;
            data1_re_r <= i_data_r;
            data1_im_r <= i_data_i;
         end
      end
   end

   assign o_valid   = valid_r;
   assign o_first   = first_r;
   assign o_last    = last_r;
   assign o_data0_r = data0_re_r;
   assign o_data0_i = data0_im_r;
   assign o_data1_r = data1_re_r;
   assign o_data1_i = data1_im_r;

endmodule

// File: tb/tb_btfly_2_pair_buffer.sv
// Self-checking bench for btfly_2_pair_buffer: directed scenarios plus random
// traffic, compared every cycle against a block-position reference model.
module tb_btfly_2_pair_buffer;

   localparam int NB_DATA = 8;
   localparam int DEPTH   = 4;
   localparam int NB_BLK  = 2 * DEPTH;
   localparam int NB_VEC  = 3 + 4 * NB_DATA;

   logic               i_clock = 1'b0;
   logic               i_rst_n;
   logic               i_valid;
   logic               i_sync;
   logic [NB_DATA-1:0] i_data_r;
   logic [NB_DATA-1:0] i_data_i;
   logic               o_valid;
   logic               o_first;
   logic               o_last;
   logic [NB_DATA-1:0] o_data0_r;
   logic [NB_DATA-1:0] o_data0_i;
   logic [NB_DATA-1:0] o_data1_r;
   logic [NB_DATA-1:0] o_data1_i;

   btfly_2_pair_buffer #(.NB_DATA(NB_DATA), .DEPTH(DEPTH)) dut (
      .i_clock  (i_clock),
      .i_rst_n  (i_rst_n),
      .i_valid  (i_valid),
      .i_sync   (i_sync),
      .i_data_r (i_data_r),
      .i_data_i (i_data_i),
      .o_valid  (o_valid),
      .o_first  (o_first),
      .o_last   (o_last),
      .o_data0_r(o_data0_r),
      .o_data0_i(o_data0_i),
      .o_data1_r(o_data1_r),
      .o_data1_i(o_data1_i)
   );

   always #5 i_clock = ~i_clock;

   int checks = 0;
   int errors = 0;

   // Reference model: position within the current block and that block's samples.
   int                 pos;
   logic [NB_DATA-1:0] blk_r [NB_BLK];
   logic [NB_DATA-1:0] blk_i [NB_BLK];
   logic [NB_VEC-1:0]  exp_vec;
   logic [NB_VEC-1:0]  got_vec;
   int                 n_valid, n_first, n_last;

   assign got_vec = {o_valid, o_first, o_last, o_data0_r, o_data0_i, o_data1_r, o_data1_i};

   // Drive one cycle of input, advance the model, and return just after the edge.
   task automatic step(input logic v, input logic s, input logic [NB_DATA-1:0] r,
                       input logic [NB_DATA-1:0] im);
      @(negedge i_clock);
      i_valid  = v;
      i_sync   = s;
      i_data_r = r;
      i_data_i = im;
      if (!i_rst_n) begin
         pos     = 0;
         exp_vec = '0;
      end else if (v) begin
         if (s || pos == NB_BLK) pos = 0;
         blk_r[pos] = r;
         blk_i[pos] = im;
         if (pos >= DEPTH)
            exp_vec = {1'b1, pos == DEPTH, pos == NB_BLK - 1,
                       blk_r[pos-DEPTH], blk_i[pos-DEPTH], r, im};
         else
            exp_vec[NB_VEC-1] = 1'b0;
         pos++;
      end else begin
         exp_vec[NB_VEC-1] = 1'b0;
      end
      @(posedge i_clock);
      #1;
   endtask

   task automatic clear_counts();
      n_valid = 0;
      n_first = 0;
      n_last  = 0;
   endtask

   task automatic tally();
      if (o_valid) n_valid++;
      if (o_valid && o_first) n_first++;
      if (o_valid && o_last) n_last++;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         step(1'b1, k == 0, 8'($urandom), 8'($urandom));
         checks++;
         if (got_vec !== '0) begin
            errors++;
            $display("FAIL reset_state cyc=%0d got=%h exp=0", k, got_vec);
         end
      end
      i_rst_n = 1'b1;
   endtask

   task automatic test_ramp();
      clear_counts();
      for (int k = 0; k < NB_BLK; k++) begin
         step(1'b1, k == 0, 8'(k), 8'(-k));
         tally();
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL ramp k=%0d got=%h exp=%h", k, got_vec, exp_vec);
         end
         checks++;
         if (o_valid !== (k >= DEPTH)) begin
            errors++;
            $display("FAIL ramp_timing k=%0d got=%b exp=%b", k, o_valid, k >= DEPTH);
         end
      end
      checks++;
      if (n_valid != 4 || n_first != 1 || n_last != 1) begin
         errors++;
         $display("FAIL ramp_counts got=%0d/%0d/%0d exp=4/1/1", n_valid, n_first, n_last);
      end
   endtask

   task automatic test_gaps();
      clear_counts();
      for (int k = 0; k < NB_BLK; k++) begin
         step(1'b1, k == 0, 8'(k), 8'(-k));
         tally();
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL gaps_data k=%0d got=%h exp=%h", k, got_vec, exp_vec);
         end
         step(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
         tally();
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL gaps_hold k=%0d got=%h exp=%h", k, got_vec, exp_vec);
         end
      end
      checks++;
      if (n_valid != 4) begin
         errors++;
         $display("FAIL gaps_count got=%0d exp=4", n_valid);
      end
   endtask

   task automatic test_extremes();
      logic [NB_DATA-1:0] ext [NB_BLK];
      ext = '{8'h80, 8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h80, 8'h7F, 8'h80};
      for (int k = 0; k < NB_BLK; k++) begin
         step(1'b1, k == 0, ext[k], ~ext[k]);
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL extremes k=%0d got=%h exp=%h", k, got_vec, exp_vec);
         end
         if (k == DEPTH) begin
            checks++;
            if (o_data0_r !== 8'h80 || o_data1_r !== 8'h7F) begin
               errors++;
               $display("FAIL extremes_pair0 got=%h,%h exp=80,7f", o_data0_r, o_data1_r);
            end
         end
      end
   endtask

   task automatic test_resync();
      clear_counts();
      for (int k = 0; k < 14; k++) begin
         if (k < 6) step(1'b1, k == 0, 8'(k), 8'(k + 100));
         else       step(1'b1, k == 6, 8'(k + 4), 8'(k + 104));
         tally();
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL resync k=%0d got=%h exp=%h", k, got_vec, exp_vec);
         end
      end
      checks++;
      if (n_valid != 6 || n_first != 2 || n_last != 1) begin
         errors++;
         $display("FAIL resync_counts got=%0d/%0d/%0d exp=6/2/1", n_valid, n_first, n_last);
      end
   endtask

   task automatic test_reset_mid_block();
      clear_counts();
      for (int k = 0; k < 7; k++) step(1'b1, k == 0, 8'(k + 50), 8'(k + 60));
      #2;
      i_rst_n = 1'b0;
      #1;
      checks++;
      if (got_vec !== '0) begin
         errors++;
         $display("FAIL reset_async got=%h exp=0", got_vec);
      end
      step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
      step(1'b0, 1'b0, 8'($urandom), 8'($urandom));
      i_rst_n = 1'b1;
      for (int k = 0; k < NB_BLK; k++) begin
         step(1'b1, 1'b0, 8'(k + 20), 8'(-(k + 20)));
         tally();
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL reset_restart k=%0d got=%h exp=%h", k, got_vec, exp_vec);
         end
      end
      checks++;
      if (n_valid != 4 || n_first != 1 || n_last != 1) begin
         errors++;
         $display("FAIL reset_counts got=%0d/%0d/%0d exp=4/1/1", n_valid, n_first, n_last);
      end
   endtask

   task automatic test_back_to_back();
      clear_counts();
      for (int k = 0; k < 3 * NB_BLK; k++) begin
         step(1'b1, k == 0, 8'($urandom), 8'($urandom));
         tally();
         checks++;
         if (got_vec !== exp_vec || o_valid !== ((k % NB_BLK) >= DEPTH)) begin
            errors++;
            $display("FAIL back_to_back k=%0d got=%h exp=%h", k, got_vec, exp_vec);
         end
      end
      checks++;
      if (n_valid != 12 || n_first != 3 || n_last != 3) begin
         errors++;
         $display("FAIL b2b_counts got=%0d/%0d/%0d exp=12/3/3", n_valid, n_first, n_last);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
              8'($urandom), 8'($urandom));
         checks++;
         if (got_vec !== exp_vec) begin
            errors++;
            $display("FAIL random k=%0d got=%h exp=%h", k, got_vec, exp_vec);
         end
      end
   endtask

   initial begin
      i_rst_n  = 1'b0;
      i_valid  = 1'b0;
      i_sync   = 1'b0;
      i_data_r = '0;
      i_data_i = '0;
      pos      = 0;
      exp_vec  = '0;
      test_reset();
      test_ramp();
      test_gaps();
      test_extremes();
      test_resync();
      test_reset_mid_block();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
